// File: rtl/datapath_exec_ctrl.sv
// datapath_exec_ctrl: run/step sequencer sitting between the UART RX FIFO,
//   the pipeline enable/clear and the debug dump engine.
// Latency: a command byte is decoded and popped in the cycle it is presented.
//   All outputs except rx_read are registered.
// Backpressure: bytes are popped only when rx_valid is high. In RUN only the
//   halt byte is popped. In DUMP and CLEAR nothing is popped.
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-high reset to IDLE
//   rx_data/rx_valid head byte of the RX FIFO and its not-empty flag
//   rx_read          combinational one-cycle pop strobe to the RX FIFO
//   eop              end-of-program flag from MEM/WB
//   dump_done        dump engine finished pulse
//   datapath_en      pipeline/PC enable
//   datapath_rst     synchronous clear for the PC and pipeline registers
//   dump_start       one-cycle dump request pulse
//   busy             high in every state except IDLE and DONE
//   timeout          sticky flag: the last run stopped on MAX_CYCLES
//   cycle_count      enabled cycles since the last CLEAR (saturating)
//   state_dbg        IDLE=0 RUN=1 STEP=2 DUMP=3 CLEAR=4 DONE=5 (BPWAIT=6)
// Optional: define EXEC_CTRL_BREAKPOINT_EN to add pc_in/bp_hit and the 'b'
//   command, which loads a one-entry PC breakpoint.

module datapath_exec_ctrl #(
  parameter int          CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 32'h0000_FFFF,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_read,
  input  logic             eop,
  input  logic             dump_done,
  output logic             datapath_en,
  output logic             datapath_rst,
  output logic             dump_start,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       state_dbg
`ifdef EXEC_CTRL_BREAKPOINT_EN
  ,
  input  logic [7:0]       pc_in,
  output logic             bp_hit
`endif
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RUN    = 3'd1;
  localparam logic [2:0] STEP   = 3'd2;
  localparam logic [2:0] DUMP   = 3'd3;
  localparam logic [2:0] CLEAR  = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
`ifdef EXEC_CTRL_BREAKPOINT_EN
  localparam logic [2:0] BPWAIT = 3'd6;
  localparam logic [7:0] CMD_BP = 8'h62;
`endif

  localparam logic [7:0] CMD_RUN   = 8'h72;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_CLEAR = 8'h63;
  localparam logic [7:0] CMD_HALT  = 8'h68;

  logic [2:0]  state;
  logic [2:0]  nextState;
  logic [31:0] runCnt;     // enabled cycles in the current run only
  logic [31:0] rstCnt;     // cycles spent in CLEAR so far
  logic        eopSeen;
  logic        readReq;
  logic        timeoutHit;
  logic        bpMatch;
  logic        bpHitSet;
  logic        bpLoad;

  // Next-cycle values for the registered outputs.
  logic        enD;
  logic        rstD;
  logic        startD;
  logic        busyD;
  logic        enterClear;
  logic        startRun;

`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic [7:0]  bpAddr;
  logic        bpValid;
  assign bpMatch = bpValid && (pc_in == bpAddr);
`else
  assign bpMatch = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------
  // Next-state decode, including the combinational pop strobe
  // ---------------------------------------------------------------------
  always_comb begin
    nextState  = state;
    readReq    = 1'b0;
    timeoutHit = 1'b0;
    bpHitSet   = 1'b0;
    bpLoad     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          readReq = 1'b1;
          case (rx_data)
            CMD_RUN:   nextState = RUN;
            CMD_STEP:  nextState = STEP;
            CMD_CLEAR: nextState = CLEAR;
`ifdef EXEC_CTRL_BREAKPOINT_EN
            CMD_BP:    nextState = BPWAIT;
`endif
            default:   nextState = IDLE;
          endcase
        end
      end
      RUN: begin
        // eop > breakpoint > halt byte > timeout. The halt byte is only
        // popped when it actually causes the stop.
        if (eop) begin
          nextState = DUMP;
        end else if (bpMatch) begin
          nextState = DUMP;
          bpHitSet  = 1'b1;
        end else if (rx_valid && rx_data == CMD_HALT) begin
          readReq   = 1'b1;
          nextState = DUMP;
        end else if (runCnt + 32'd1 >= MAX_CYCLES) begin
          timeoutHit = 1'b1;
          nextState  = DUMP;
        end
      end
      STEP: nextState = DUMP;
      DUMP: begin
        if (dump_done) nextState = eopSeen ? DONE : IDLE;
      end
      CLEAR: begin
        if (rstCnt + 32'd1 >= RST_CYCLES) nextState = IDLE;
      end
      DONE: begin
        // Only clear leaves DONE; everything else is drained and dropped.
        if (rx_valid) begin
          readReq = 1'b1;
          if (rx_data == CMD_CLEAR) nextState = CLEAR;
        end
      end
`ifdef EXEC_CTRL_BREAKPOINT_EN
      BPWAIT: begin
        if (rx_valid) begin
          readReq   = 1'b1;
          bpLoad    = 1'b1;
          nextState = IDLE;
        end
      end
`endif
      default: nextState = IDLE;
    endcase
  end

  // Never pop while the FIFO is empty or while held in reset.
  assign rx_read = readReq && rx_valid && !reset;

  // ---------------------------------------------------------------------
  // Output decode (values the registered outputs take next cycle)
  // ---------------------------------------------------------------------
  always_comb begin
    enD        = (nextState == RUN) || (nextState == STEP);
    rstD       = (nextState == CLEAR);
    startD     = (nextState == DUMP) && (state != DUMP);
    busyD      = (nextState != IDLE) && (nextState != DONE);
    enterClear = (nextState == CLEAR) && (state != CLEAR);
    startRun   = (state == IDLE) && ((nextState == RUN) || (nextState == STEP));
  end

  // ---------------------------------------------------------------------
  // Registered outputs and datapath bookkeeping
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      datapath_en  <= 1'b0;
      datapath_rst <= 1'b0;
      dump_start   <= 1'b0;
      busy         <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      eopSeen      <= 1'b0;
      runCnt       <= '0;
      rstCnt       <= '0;
    end else begin
      datapath_en  <= enD;
      datapath_rst <= rstD;
      dump_start   <= startD;
      busy         <= busyD;

      runCnt <= (state == RUN)   ? runCnt + 32'd1 : '0;
      rstCnt <= (state == CLEAR) ? rstCnt + 32'd1 : '0;

      if (enterClear) begin
        cycle_count <= '0;
      end else if ((state == RUN || state == STEP) && cycle_count != '1) begin
        cycle_count <= cycle_count + 1'b1;
      end

      if (enterClear)                             eopSeen <= 1'b0;
      else if ((state == RUN || state == STEP) && eop) eopSeen <= 1'b1;

      if (enterClear)                             timeout <= 1'b0;
      else if (state == IDLE && nextState == RUN) timeout <= 1'b0;
      else if (timeoutHit)                        timeout <= 1'b1;
    end
  end

`ifdef EXEC_CTRL_BREAKPOINT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bpAddr  <= '0;
      bpValid <= 1'b0;
      bp_hit  <= 1'b0;
    end else begin
      if (enterClear) begin
        bpValid <= 1'b0;
      end else if (bpLoad) begin
        bpAddr  <= rx_data;
        bpValid <= 1'b1;
      end
      // Sticky until the next run/step command is accepted.
      if (startRun)      bp_hit <= 1'b0;
      else if (bpHitSet) bp_hit <= 1'b1;
    end
  end
`else
  // Without breakpoints these decode terms have no consumer.
  logic unusedBp;
  assign unusedBp = bpHitSet ^ bpLoad ^ startRun;
`endif

endmodule

// File: tb/tb_datapath_exec_ctrl.sv
// tb_datapath_exec_ctrl: directed-vector bench for datapath_exec_ctrl.
// Models the RX FIFO as a byte queue and the dump engine as a fixed delay.
// Built with MAX_CYCLES=20, RST_CYCLES=4, CNT_W=4 so saturation is reachable.

module tb_datapath_exec_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_read;
  logic             eop;
  logic             dump_done;
  logic             datapath_en;
  logic             datapath_rst;
  logic             dump_start;
  logic             busy;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [2:0]       state_dbg;
`ifdef EXEC_CTRL_BREAKPOINT_EN
  logic [7:0]       pc_in;
  logic             bp_hit;
`endif

  datapath_exec_ctrl #(
    .CNT_W(CNT_W),
    .MAX_CYCLES(20),
    .RST_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_read(rx_read),
    .eop(eop),
    .dump_done(dump_done),
    .datapath_en(datapath_en),
    .datapath_rst(datapath_rst),
    .dump_start(dump_start),
    .busy(busy),
    .timeout(timeout),
    .cycle_count(cycle_count),
    .state_dbg(state_dbg)
`ifdef EXEC_CTRL_BREAKPOINT_EN
    ,
    .pc_in(pc_in),
    .bp_hit(bp_hit)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] rxQ[$];
  int nVec  = 0;
  int nMiss = 0;
  int enCnt = 0;
  int rstSeen = 0;
  int dsCnt = 0;
  int ddTimer = 0;
  int ddDelay = 3;
  logic autoDump = 1'b1;
  logic lastRead = 1'b0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic syncRx();
    rx_valid = (rxQ.size() != 0);
    rx_data  = rx_valid ? rxQ[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    rxQ.push_back(b);
    syncRx();
  endtask

  // One clock: sample the pop strobe mid-cycle, advance, then update the
  // FIFO and dump-engine models just after the edge.
  task automatic cyc();
    @(negedge clk);
    lastRead = rx_read;
    @(posedge clk);
    #1;
    if (lastRead && rxQ.size() != 0) void'(rxQ.pop_front());
    syncRx();
    enCnt   += int'(datapath_en);
    rstSeen += int'(datapath_rst);
    dsCnt   += int'(dump_start);
    dump_done = 1'b0;
    if (ddTimer > 0) begin
      ddTimer--;
      if (ddTimer == 0) dump_done = 1'b1;
    end
    if (dump_start && autoDump) begin
      if (ddDelay == 0) dump_done = 1'b1;
      else              ddTimer = ddDelay;
    end
  endtask

  task automatic waitState(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state_dbg != s && n < budget) begin
      cyc();
      n++;
    end
    checkVal(tag, 32'(state_dbg), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int ds0;
    reset = 1'b1; eop = 1'b0; dump_done = 1'b0;
`ifdef EXEC_CTRL_BREAKPOINT_EN
    pc_in = 8'h00;
`endif
    syncRx();
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_state", 32'(state_dbg), 0);
    checkVal("rst_en",    32'(datapath_en), 0);
    checkVal("rst_drst",  32'(datapath_rst), 0);
    checkVal("rst_dstart",32'(dump_start), 0);
    checkVal("rst_cnt",   32'(cycle_count), 0);
    checkVal("rst_tmo",   32'(timeout), 0);
    reset = 1'b0;
    cyc();

    // Single step, dump_done 3 cycles after dump_start.
    enCnt = 0; dsCnt = 0;
    push(8'h73);
    cyc();
    checkVal("step_state", 32'(state_dbg), 2);
    checkVal("step_en",    32'(datapath_en), 1);
    checkVal("step_popped",32'(rxQ.size()), 0);
    cyc();
    checkVal("step_dump",  32'(state_dbg), 3);
    checkVal("step_dstart",32'(dump_start), 1);
    checkVal("step_cnt",   32'(cycle_count), 1);
    waitState(3'd0, 10, "step_idle");
    checkVal("step_encnt", 32'(enCnt), 1);
    checkVal("step_dscnt", 32'(dsCnt), 1);
    checkVal("step_busy",  32'(busy), 0);

    // dump_done in the same cycle as dump_start.
    ddDelay = 0;
    push(8'h73);
    cyc(); cyc();
    checkVal("samecyc_dump", 32'(state_dbg), 3);
    cyc();
    checkVal("samecyc_idle", 32'(state_dbg), 0);
    checkVal("samecyc_cnt",  32'(cycle_count), 2);
    ddDelay = 3;

    // Run with eop on the 10th enabled cycle.
    enCnt = 0; ds0 = dsCnt;
    push(8'h72);
    cyc();
    checkVal("run_state", 32'(state_dbg), 1);
    repeat (9) cyc();
    eop = 1'b1;
    cyc();
    eop = 1'b0;
    checkVal("eop_dump",  32'(state_dbg), 3);
    checkVal("eop_en",    32'(datapath_en), 0);
    checkVal("eop_encnt", 32'(enCnt), 10);
    checkVal("eop_cnt",   32'(cycle_count), 12);
    waitState(3'd5, 20, "eop_done");
    checkVal("eop_dscnt", 32'(dsCnt - ds0), 1);
    push(8'h73);
    cyc();
    checkVal("done_popped", 32'(rxQ.size()), 0);
    checkVal("done_state",  32'(state_dbg), 5);
    checkVal("done_en",     32'(datapath_en), 0);
    checkVal("done_encnt",  32'(enCnt), 10);

    // Clear from DONE.
    rstSeen = 0;
    push(8'h63);
    cyc();
    checkVal("clr_state", 32'(state_dbg), 4);
    checkVal("clr_drst",  32'(datapath_rst), 1);
    checkVal("clr_cnt",   32'(cycle_count), 0);
    waitState(3'd0, 10, "clr_idle");
    checkVal("clr_rstcyc",32'(rstSeen), 4);
    checkVal("clr_drst0", 32'(datapath_rst), 0);

    // Timeout after 20 enabled cycles; the 4-bit counter saturates at 15.
    enCnt = 0;
    push(8'h72);
    waitState(3'd3, 40, "tmo_dump");
    checkVal("tmo_encnt", 32'(enCnt), 20);
    checkVal("tmo_flag",  32'(timeout), 1);
    checkVal("tmo_sat",   32'(cycle_count), 15);
    waitState(3'd0, 10, "tmo_idle");
    checkVal("tmo_sticky",32'(timeout), 1);

    // eop and a queued halt byte at the same edge: eop wins, 'h' stays.
    push(8'h72); push(8'h68);
    cyc();
    checkVal("pri_run",  32'(state_dbg), 1);
    checkVal("pri_tmo0", 32'(timeout), 0);
    eop = 1'b1;
    cyc();
    eop = 1'b0;
    checkVal("pri_nopop", 32'(lastRead), 0);
    checkVal("pri_dump",  32'(state_dbg), 3);
    checkVal("pri_qlen",  32'(rxQ.size()), 1);
    waitState(3'd5, 10, "pri_done");
    checkVal("pri_cnt",   32'(cycle_count), 15);

    // Reset in the middle of a dump; a late dump_done is ignored.
    push(8'h63);
    waitState(3'd0, 12, "pre_rst_idle");
    autoDump = 1'b0;
    ds0 = dsCnt;
    push(8'h73);
    cyc(); cyc();
    checkVal("mid_dump", 32'(state_dbg), 3);
    reset = 1'b1;
    #2;
    checkVal("mid_state", 32'(state_dbg), 0);
    checkVal("mid_dstart",32'(dump_start), 0);
    checkVal("mid_cnt",   32'(cycle_count), 0);
    checkVal("mid_busy",  32'(busy), 0);
    cyc();
    reset = 1'b0;
    dump_done = 1'b1;
    cyc();
    checkVal("late_state", 32'(state_dbg), 0);
    cyc();
    checkVal("late_state2",32'(state_dbg), 0);
    checkVal("late_dscnt", 32'(dsCnt - ds0), 1);
    checkVal("late_en",    32'(datapath_en), 0);
    autoDump = 1'b1;

`ifdef EXEC_CTRL_BREAKPOINT_EN
    // Breakpoint at PC 5.
    push(8'h62); push(8'h05); push(8'h72);
    pc_in = 8'h00;
    cyc(); cyc(); cyc();
    checkVal("bp_run", 32'(state_dbg), 1);
    cyc(); cyc();
    pc_in = 8'h05;
    cyc();
    checkVal("bp_dump", 32'(state_dbg), 3);
    checkVal("bp_hit",  32'(bp_hit), 1);
    checkVal("bp_en",   32'(datapath_en), 0);
    waitState(3'd0, 10, "bp_idle");
    checkVal("bp_sticky", 32'(bp_hit), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
